mem_arbiter: RTL and testbench

Two-port arbiter and sequencer placed in front of the single-port `MemoryModule` of the 32-bit RISC processor. It shares the memory between the instruction-fetch port (read-only) and the data load/store port (read/write). It drives the memory's `address`/`data`/`wr`/`rd` strobes for a fixed number of cycles and captures `data1`. It returns each requester a one-cycle acknowledge with registered read data.

---
 rtl/mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter/sequencer in front of the single-port MemoryModule.
// Build option: define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking.
module mem_arbiter #(
   parameter int ADDR_W      = 28,
   parameter int DATA_W      = 32,
   parameter int MEM_LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ack,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_ack,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_data,
   output logic              mem_wr,
   output logic              mem_rd,
   input  logic [DATA_W-1:0] mem_data1
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_DONE
   } state_t;

   localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

   state_t            state_q;
   logic [3:0]        cnt_q;
   logic              grant_dm_q;
   logic              we_q;
   logic [DATA_W-1:0] if_rdata_q;
   logic [DATA_W-1:0] dm_rdata_q;
   logic              if_ack_q;
   logic              dm_ack_q;
   logic [ADDR_W-1:0] mem_address_q;
   logic [DATA_W-1:0] mem_data_q;
   logic              mem_wr_q;
   logic              mem_rd_q;

   logic              any_req;
   logic              grant_dm_d;
   logic              we_d;

   assign any_req = if_req | dm_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic last_dm_q;

   // On a tie the port that was not served last wins
   assign grant_dm_d = dm_req & (~if_req | ~last_dm_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         last_dm_q <= 1'b0;
      end else if (state_q == S_IDLE && any_req) begin
         last_dm_q <= grant_dm_d;
      end
   end
`else
   assign grant_dm_d = dm_req;
`endif

   assign we_d = grant_dm_d & dm_we;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         grant_dm_q    <= 1'b0;
         we_q          <= 1'b0;
         if_rdata_q    <= '0;
         dm_rdata_q    <= '0;
         if_ack_q      <= 1'b0;
         dm_ack_q      <= 1'b0;
         mem_address_q <= '0;
         mem_data_q    <= '0;
         mem_wr_q      <= 1'b0;
         mem_rd_q      <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (any_req) begin
                  grant_dm_q    <= grant_dm_d;
                  we_q          <= we_d;
                  cnt_q         <= CNT_INIT;
                  mem_address_q <= grant_dm_d ? dm_addr : if_addr;
                  mem_data_q    <= we_d ? dm_wdata : '0;
                  mem_wr_q      <= we_d;
                  mem_rd_q      <= ~we_d;
                  state_q       <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               if (cnt_q == 4'd0) begin
                  if (!we_q) begin
                     if (grant_dm_q) begin
                        dm_rdata_q <= mem_data1;
                     end else begin
                        if_rdata_q <= mem_data1;
                     end
                  end
                  mem_address_q <= '0;
                  mem_data_q    <= '0;
                  mem_wr_q      <= 1'b0;
                  mem_rd_q      <= 1'b0;
                  dm_ack_q      <= grant_dm_q;
                  if_ack_q      <= ~grant_dm_q;
                  state_q       <= S_DONE;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            S_DONE: begin
               dm_ack_q <= 1'b0;
               if_ack_q <= 1'b0;
               state_q  <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign if_rdata    = if_rdata_q;
   assign dm_rdata    = dm_rdata_q;
   assign if_ack      = if_ack_q;
   assign dm_ack      = dm_ack_q;
   assign mem_address = mem_address_q;
   assign mem_data    = mem_data_q;
   assign mem_wr      = mem_wr_q;
   assign mem_rd      = mem_rd_q;

   a_one_strobe: assert property (@(posedge clk) !(mem_rd_q && mem_wr_q));
   a_one_ack:    assert property (@(posedge clk) !(if_ack_q && dm_ack_q));

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random stimulus against a transaction-level model.
// Honours MEM_ARB_ROUND_ROBIN_EN the same way as the design.
module tb_mem_arbiter;

   localparam int L = 2;
`ifdef MEM_ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [27:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ack;
   logic        dm_req;
   logic        dm_we;
   logic [27:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [31:0] dm_rdata;
   logic        dm_ack;
   logic [27:0] mem_address;
   logic [31:0] mem_data;
   logic        mem_wr;
   logic        mem_rd;
   logic [31:0] mem_data1;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mem_arbiter #(
      .ADDR_W(28),
      .DATA_W(32),
      .MEM_LATENCY(L)
   ) dut (
      .clk(clk),
      .rst(rst),
      .if_req(if_req),
      .if_addr(if_addr),
      .if_rdata(if_rdata),
      .if_ack(if_ack),
      .dm_req(dm_req),
      .dm_we(dm_we),
      .dm_addr(dm_addr),
      .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata),
      .dm_ack(dm_ack),
      .mem_address(mem_address),
      .mem_data(mem_data),
      .mem_wr(mem_wr),
      .mem_rd(mem_rd),
      .mem_data1(mem_data1)
   );

   // Stand-in for MemoryModule: 16 words, initial word i = 0x1000_0000 + i
   logic [31:0] ram [16];
   bit          ram_init_done;

   always @(posedge clk) begin
      if (!ram_init_done) begin
         for (int i = 0; i < 16; i++) ram[i] <= 32'h1000_0000 + i;
         ram_init_done <= 1'b1;
      end else if (mem_wr) begin
         ram[mem_address[3:0]] <= mem_data;
      end
   end

   always_comb begin
      mem_data1 = 32'hDEAD_BEEF;
      if (mem_rd) mem_data1 = ram[mem_address[3:0]];
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Transaction-level model: ph counts cycles since the grant cycle
   int          ph = -1;
   bit          armed = 1'b0;
   bit          t_dm, t_we, last_dm;
   logic [27:0] t_addr;
   logic [31:0] t_wdata;
   logic [31:0] m_if_rd, m_dm_rd;
   logic [31:0] refmem [16];
   bit          act;

   initial begin
      for (int i = 0; i < 16; i++) refmem[i] = 32'h1000_0000 + i;
   end

   always @(negedge clk) begin
      if (armed) begin
         act = (ph >= 1) && (ph <= L);
         chk("mem_rd", mem_rd, act && !t_we);
         chk("mem_wr", mem_wr, act && t_we);
         chk("mem_address", mem_address, act ? t_addr : 28'd0);
         chk("mem_data", mem_data, (act && t_we) ? t_wdata : 32'd0);
         chk("if_ack", if_ack, (ph == L + 1) && !t_dm);
         chk("dm_ack", dm_ack, (ph == L + 1) && t_dm);
         chk("if_rdata", if_rdata, m_if_rd);
         chk("dm_rdata", dm_rdata, m_dm_rd);
      end
      if (rst) begin
         ph      = -1;
         m_if_rd = '0;
         m_dm_rd = '0;
         last_dm = 1'b0;
         armed   = 1'b1;
      end else if (ph < 0) begin
         if (dm_req || if_req) begin
            if (dm_req && if_req) t_dm = RR ? !last_dm : 1'b1;
            else t_dm = dm_req;
            t_we    = t_dm && dm_we;
            t_addr  = t_dm ? dm_addr : if_addr;
            t_wdata = dm_wdata;
            if (t_we) refmem[t_addr[3:0]] = t_wdata;
            last_dm = t_dm;
            ph      = 1;
         end
      end else begin
         if (ph == L && !t_we) begin
            if (t_dm) m_dm_rd = refmem[t_addr[3:0]];
            else m_if_rd = refmem[t_addr[3:0]];
         end
         ph = (ph == L + 1) ? -1 : ph + 1;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Single transaction on an idle arbiter; disturbs inputs after the grant
   task automatic txn(input bit dm, input bit we, input logic [27:0] a,
                      input logic [31:0] wd, input logic [31:0] exp_rd);
      step();
      if (dm) begin
         dm_req = 1'b1; dm_we = we; dm_addr = a; dm_wdata = wd;
      end else begin
         if_req = 1'b1; if_addr = a;
      end
      step();
      dm_req = 1'b0; if_req = 1'b0;
      dm_addr = a ^ 28'hC; if_addr = a ^ 28'hC;
      dm_wdata = ~wd; dm_we = ~we;
      for (int c = 1; c <= L; c++) begin
         @(negedge clk);
         chk("txn_wr", mem_wr, dm && we);
         chk("txn_rd", mem_rd, !(dm && we));
         chk("txn_addr", mem_address, a);
         chk("txn_data", mem_data, (dm && we) ? wd : 32'd0);
         if (c < L) step();
      end
      step();
      @(negedge clk);
      chk("txn_ack", dm ? dm_ack : if_ack, 1'b1);
      chk("txn_other_ack", dm ? if_ack : dm_ack, 1'b0);
      chk("txn_strobe_done", {31'd0, mem_rd | mem_wr}, 32'd0);
      if (!(dm && we)) chk("txn_rdata", dm ? dm_rdata : if_rdata, exp_rd);
      step();
      @(negedge clk);
      chk("txn_ack_gone", {31'd0, dm_ack | if_ack}, 32'd0);
      if (!(dm && we)) chk("txn_rdata_held", dm ? dm_rdata : if_rdata, exp_rd);
   endtask

   initial begin
      rst = 1'b1;
      if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b1;
      if_addr = '0; dm_addr = '0; dm_wdata = '0;
      for (int c = 0; c < 3; c++) begin
         step();
         if_addr = 28'($urandom); dm_addr = 28'($urandom);
         dm_wdata = $urandom; dm_we = 1'($urandom);
         @(negedge clk);
         chk("rst_strobes", {30'd0, mem_rd, mem_wr}, 32'd0);
         chk("rst_acks", {30'd0, if_ack, dm_ack}, 32'd0);
         chk("rst_addr", mem_address, 28'd0);
         chk("rst_data", mem_data, 32'd0);
         chk("rst_rdata", if_rdata | dm_rdata, 32'd0);
      end
      step();
      rst = 1'b0; if_req = 1'b0; dm_req = 1'b0;
      for (int c = 0; c < 3; c++) begin
         step();
         @(negedge clk);
         chk("idle_strobes", {30'd0, mem_rd, mem_wr}, 32'd0);
      end

      txn(1'b1, 1'b1, 28'd5, 32'hA5A5_A5A5, 32'd0);
      txn(1'b1, 1'b0, 28'd5, 32'd0, 32'hA5A5_A5A5);
      txn(1'b0, 1'b0, 28'd5, 32'd0, 32'hA5A5_A5A5);

      // Simultaneous requests
      step();
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 28'd5;
      if_req = 1'b1; if_addr = 28'd3;
      for (int c = 1; c <= 16; c++) begin
         step();
         if (!RR) begin
            if (dm_ack) dm_req = 1'b0;
            if (if_ack) if_req = 1'b0;
         end else if (c == 15) begin
            dm_req = 1'b0; if_req = 1'b0;
         end
         @(negedge clk);
         if (c == 3) chk("tie_first_dm", {30'd0, dm_ack, if_ack}, 32'd2);
         if (c == 7) begin
            chk("tie_second_if", {30'd0, dm_ack, if_ack}, 32'd1);
            chk("tie_if_rdata", if_rdata, 32'h1000_0003);
         end
         if (c == 11) chk("tie_third", {30'd0, dm_ack, if_ack}, RR ? 32'd2 : 32'd0);
         if (c == 15) chk("tie_fourth", {30'd0, dm_ack, if_ack}, RR ? 32'd1 : 32'd0);
      end

      // Reset in the first access cycle of a read
      step();
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 28'd5;
      step();
      dm_req = 1'b0; rst = 1'b1;
      @(negedge clk);
      chk("abort_rd_before", mem_rd, 1'b1);
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("abort_strobe", {30'd0, mem_rd, mem_wr}, 32'd0);
      chk("abort_addr", mem_address, 28'd0);
      chk("abort_acks", {30'd0, dm_ack, if_ack}, 32'd0);
      chk("abort_rdata", dm_rdata | if_rdata, 32'd0);
      step();
      @(negedge clk);
      chk("abort_no_ack", {30'd0, dm_ack, if_ack}, 32'd0);
      txn(1'b1, 1'b0, 28'd5, 32'd0, 32'hA5A5_A5A5);

      // Random traffic
      for (int c = 0; c < 4000; c++) begin
         step();
         rst = ($urandom_range(0, 499) == 0);
         if (dm_ack) begin
            if ($urandom_range(0, 1) == 0) dm_req = 1'b0;
            else begin
               dm_we = 1'($urandom); dm_addr = 28'($urandom_range(0, 15));
               dm_wdata = $urandom;
            end
         end else if (!dm_req && $urandom_range(0, 9) < 3) begin
            dm_req = 1'b1; dm_we = 1'($urandom);
            dm_addr = 28'($urandom_range(0, 15)); dm_wdata = $urandom;
         end else if ($urandom_range(0, 19) == 0) begin
            dm_addr = 28'($urandom_range(0, 15)); dm_wdata = $urandom;
         end
         if (if_ack) begin
            if ($urandom_range(0, 1) == 0) if_req = 1'b0;
            else if_addr = 28'($urandom_range(0, 15));
         end else if (!if_req && $urandom_range(0, 9) < 4) begin
            if_req = 1'b1; if_addr = 28'($urandom_range(0, 15));
         end
      end
      step();
      rst = 1'b0; dm_req = 1'b0; if_req = 1'b0;
      repeat (L + 4) step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
